// File: rtl/packet_que.sv
// packet_que: multi-packet receive queue with commit/rollback and FWFT drain.
// Define PACKET_QUE_STATS_EN to add saturating drop_count/bad_count outputs.
module packet_que #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_DEPTH  = 1024,
    parameter int MAX_PACKETS = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         data_enable,
    input  logic                         good_packet,
    input  logic                         bad_packet,
    input  logic                         push_data_enable,
    output logic                         ready,
    output logic                         data_ready,
    output logic [DATA_WIDTH-1:0]        push_data,
    output logic                         push_data_valid,
    output logic                         push_data_last,
    output logic [$clog2(MAX_PACKETS):0] packet_count,
    output logic                         overflow
`ifdef PACKET_QUE_STATS_EN
    ,
    output logic [15:0]                  drop_count,
    output logic [15:0]                  bad_count
`endif
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam int LA = $clog2(MAX_PACKETS);
    localparam int LW = LA + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DATA_DEPTH);
    localparam logic [LW-1:0] MAXP_P  = LW'(MAX_PACKETS);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] remain_q, remain_d;
    logic [LW-1:0] len_wr_q, len_wr_d;
    logic [LW-1:0] len_rd_q, len_rd_d;
    logic          ready_q, ready_d;
    logic          data_ready_q, data_ready_d;
    logic          overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [PW-1:0]         len_mem_q [MAX_PACKETS];

    logic          mem_we;
    logic          len_push;
    logic          bad_discard;
    logic          space_ok;
    logic [PW-1:0] free;
    logic [PW-1:0] free_d;
    logic [PW-1:0] wr_next;
    logic [PW-1:0] new_len;
    logic [LW-1:0] count;
    logic [LW-1:0] count_d;

    assign free  = DEPTH_P - (wr_ptr_q - rd_ptr_q);
    assign count = len_wr_q - len_rd_q;

    // Write side: words accumulate past commit_ptr until good/bad decides.
    always_comb begin
        wstate_d     = wstate_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_wr_d     = len_wr_q;
        mem_we       = 1'b0;
        len_push     = 1'b0;
        overflow_d   = 1'b0;
        bad_discard  = 1'b0;
        wr_next      = wr_ptr_q;
        space_ok     = (wstate_q == W_IDLE) ? ready_q : (free != '0);
        new_len      = wr_ptr_q - commit_ptr_q;
        unique case (wstate_q)
            W_IDLE, W_FILL: begin
                if (data_enable) begin
                    if (space_ok) begin
                        mem_we  = 1'b1;
                        wr_next = wr_ptr_q + ONE_P;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                new_len = wr_next - commit_ptr_q;
                if (overflow_d) begin
                    wr_ptr_d = commit_ptr_q;
                    wstate_d = (good_packet || bad_packet) ? W_IDLE : W_DROP;
                end else if (bad_packet) begin
                    wr_ptr_d    = commit_ptr_q;
                    bad_discard = (new_len != '0);
                    wstate_d    = W_IDLE;
                end else if (good_packet) begin
                    wr_ptr_d = wr_next;
                    if (new_len != '0) begin
                        len_push     = 1'b1;
                        commit_ptr_d = wr_next;
                        len_wr_d     = len_wr_q + ONE_L;
                    end
                    wstate_d = W_IDLE;
                end else begin
                    wr_ptr_d = wr_next;
                    if (mem_we) wstate_d = W_FILL;
                end
            end
            W_DROP: begin
                if (good_packet || bad_packet) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rd_ptr_d = rd_ptr_q;
        remain_d = remain_q;
        len_rd_d = len_rd_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (count != '0) begin
                    remain_d = len_mem_q[len_rd_q[LA-1:0]];
                    rstate_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (push_data_enable) begin
                    rd_ptr_d = rd_ptr_q + ONE_P;
                    remain_d = remain_q - ONE_P;
                    if (remain_q == ONE_P) begin
                        len_rd_d = len_rd_q + ONE_L;
                        rstate_d = R_IDLE;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // ready tracks the post-edge state so it never lags a fill or a pop.
    always_comb begin
        free_d       = DEPTH_P - (wr_ptr_d - rd_ptr_d);
        count_d      = len_wr_d - len_rd_d;
        ready_d      = (free_d != '0) && (count_d != MAXP_P);
        data_ready_d = (count != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q     <= W_IDLE;
            rstate_q     <= R_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            remain_q     <= '0;
            len_wr_q     <= '0;
            len_rd_q     <= '0;
            ready_q      <= 1'b0;
            data_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wstate_q     <= wstate_d;
            rstate_q     <= rstate_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            remain_q     <= remain_d;
            len_wr_q     <= len_wr_d;
            len_rd_q     <= len_rd_d;
            ready_q      <= ready_d;
            data_ready_q <= data_ready_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= data;
        if (len_push) len_mem_q[len_wr_q[LA-1:0]] <= new_len;
    end

    assign ready           = ready_q;
    assign data_ready      = data_ready_q;
    assign overflow        = overflow_q;
    assign packet_count    = count;
    assign push_data_valid = (rstate_q == R_DRAIN);
    assign push_data_last  = push_data_valid && (remain_q == ONE_P);
    assign push_data       = push_data_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

`ifdef PACKET_QUE_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [15:0] bad_count_q, bad_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        bad_count_d  = bad_count_q;
        if (overflow_d && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;
        if (bad_discard && bad_count_q != 16'hFFFF)
            bad_count_d = bad_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= '0;
            bad_count_q  <= '0;
        end else begin
            drop_count_q <= drop_count_d;
            bad_count_q  <= bad_count_d;
        end
    end

    assign drop_count = drop_count_q;
    assign bad_count  = bad_count_q;
`endif

endmodule

// File: tb/tb_packet_que.sv
// tb_packet_que: directed checks of packet_que with a 16-word store
// and room for two committed packets.
module tb_packet_que;

    localparam int DW = 8;
    localparam int DD = 16;
    localparam int MP = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] data = '0;
    logic          data_enable = 1'b0;
    logic          good_packet = 1'b0;
    logic          bad_packet = 1'b0;
    logic          push_data_enable = 1'b0;
    logic          ready;
    logic          data_ready;
    logic [DW-1:0] push_data;
    logic          push_data_valid;
    logic          push_data_last;
    logic [1:0]    packet_count;
    logic          overflow;
`ifdef PACKET_QUE_STATS_EN
    logic [15:0]   drop_count;
    logic [15:0]   bad_count;
`endif

    int compared = 0;
    int mismatched = 0;

    packet_que #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DD),
        .MAX_PACKETS(MP)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .data            (data),
        .data_enable     (data_enable),
        .good_packet     (good_packet),
        .bad_packet      (bad_packet),
        .push_data_enable(push_data_enable),
        .ready           (ready),
        .data_ready      (data_ready),
        .push_data       (push_data),
        .push_data_valid (push_data_valid),
        .push_data_last  (push_data_last),
        .packet_count    (packet_count),
        .overflow        (overflow)
`ifdef PACKET_QUE_STATS_EN
        ,
        .drop_count      (drop_count),
        .bad_count       (bad_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] d);
        data = d;
        data_enable = 1'b1;
        cyc();
        data_enable = 1'b0;
    endtask

    // Final word together with good_packet in the same cycle.
    task automatic put_commit(input logic [DW-1:0] d);
        data = d;
        data_enable = 1'b1;
        good_packet = 1'b1;
        cyc();
        data_enable = 1'b0;
        good_packet = 1'b0;
    endtask

    task automatic commit();
        good_packet = 1'b1;
        cyc();
        good_packet = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [DW-1:0] d,
                       input logic l);
        int n;
        n = 0;
        while (push_data_valid !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        chk({tag, "_valid"}, 32'(push_data_valid), 32'd1);
        chk({tag, "_data"}, 32'(push_data), 32'(d));
        chk({tag, "_last"}, 32'(push_data_last), 32'(l));
        push_data_enable = 1'b1;
        cyc();
        push_data_enable = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_dready"}, 32'(data_ready), 32'd0);
        chk({tag, "_valid"}, 32'(push_data_valid), 32'd0);
        chk({tag, "_last"}, 32'(push_data_last), 32'd0);
        chk({tag, "_count"}, 32'(packet_count), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_data"}, 32'(push_data), 32'd0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk_reset_outputs("rst");
        #9 reset_n = 1'b1;
        cyc();
        chk("rst_ready_up", 32'(ready), 32'd1);

        // Basic three-word packet
        put(8'h11);
        put(8'h22);
        put(8'h33);
        commit();
        chk("t1_count", 32'(packet_count), 32'd1);
        chk("t1_dready_early", 32'(data_ready), 32'd0);
        cyc();
        chk("t1_dready", 32'(data_ready), 32'd1);
        chk("t1_valid", 32'(push_data_valid), 32'd1);
        pop("t1_w0", 8'h11, 1'b0);
        pop("t1_w1", 8'h22, 1'b0);
        pop("t1_w2", 8'h33, 1'b1);
        chk("t1_count_end", 32'(packet_count), 32'd0);
        chk("t1_valid_end", 32'(push_data_valid), 32'd0);

        // Commit A, discard C (bad and good together), commit B
        put(8'hA1);
        put(8'hA2);
        put(8'hA3);
        put(8'hA4);
        commit();
        chk("t2_countA", 32'(packet_count), 32'd1);
        put(8'hC1);
        put(8'hC2);
        data = 8'hC3;
        data_enable = 1'b1;
        good_packet = 1'b1;
        bad_packet = 1'b1;
        cyc();
        data_enable = 1'b0;
        good_packet = 1'b0;
        bad_packet = 1'b0;
        chk("t2_bad_wins", 32'(packet_count), 32'd1);
        put(8'hB1);
        put_commit(8'hB2);
        chk("t2_countB", 32'(packet_count), 32'd2);
        chk("t2_full", 32'(ready), 32'd0);
        pop("t2_a0", 8'hA1, 1'b0);
        pop("t2_a1", 8'hA2, 1'b0);
        pop("t2_a2", 8'hA3, 1'b0);
        pop("t2_a3", 8'hA4, 1'b1);
        chk("t2_ready_back", 32'(ready), 32'd1);
        chk("t2_count1", 32'(packet_count), 32'd1);
        pop("t2_b0", 8'hB1, 1'b0);
        pop("t2_b1", 8'hB2, 1'b1);
        chk("t2_count0", 32'(packet_count), 32'd0);

        // good_packet with no words commits nothing
        commit();
        cyc();
        chk("t2z_count", 32'(packet_count), 32'd0);
        chk("t2z_dready", 32'(data_ready), 32'd0);
        chk("t2z_valid", 32'(push_data_valid), 32'd0);

        // Overflow: 17 words into a 16-word store
        for (int i = 0; i < 16; i++) put(8'(8'h40 + i));
        chk("t3_ready_full", 32'(ready), 32'd0);
        chk("t3_no_ovf", 32'(overflow), 32'd0);
        put(8'h50);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_ready_back", 32'(ready), 32'd1);
        commit();
        chk("t3_ovf_pulse", 32'(overflow), 32'd0);
        chk("t3_count", 32'(packet_count), 32'd0);
        cyc();
        chk("t3_dready", 32'(data_ready), 32'd0);
        chk("t3_valid", 32'(push_data_valid), 32'd0);
`ifdef PACKET_QUE_STATS_EN
        chk("t3_drop_count", 32'(drop_count), 32'd1);
        chk("t3_bad_count", 32'(bad_count), 32'd1);
`endif

        // Packet-count limit with single-word packets
        put_commit(8'hD1);
        chk("t4_count1", 32'(packet_count), 32'd1);
        chk("t4_ready1", 32'(ready), 32'd1);
        put_commit(8'hD2);
        chk("t4_count2", 32'(packet_count), 32'd2);
        chk("t4_ready0", 32'(ready), 32'd0);
        pop("t4_d1", 8'hD1, 1'b1);
        chk("t4_ready_back", 32'(ready), 32'd1);
        chk("t4_count_back", 32'(packet_count), 32'd1);
        pop("t4_d2", 8'hD2, 1'b1);
        chk("t4_count0", 32'(packet_count), 32'd0);

        // Wrap-around: five 10-word packets through a 16-word store
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 10; i++) put(8'(k * 16 + i));
            commit();
            for (int i = 0; i < 10; i++)
                pop("t5_wrap", 8'(k * 16 + i), (i == 9));
        end
        chk("t5_count", 32'(packet_count), 32'd0);
        chk("t5_ready", 32'(ready), 32'd1);

        // Reset in the middle of a drain
        put(8'h61);
        put(8'h62);
        put(8'h63);
        commit();
        pop("t6_w0", 8'h61, 1'b0);
        chk("t6_pre_valid", 32'(push_data_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        reset_n = 1'b1;
        cyc();
        chk("t6_ready_up", 32'(ready), 32'd1);
        put_commit(8'h5A);
        pop("t6_new", 8'h5A, 1'b1);
        chk("t6_count", 32'(packet_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
